// File: rtl/tpose_nxn_dbuf.sv
// NxN-block stream transposer with ping-pong banks, per-block bypass,
// end-of-stream propagation and a sticky protocol error flag.

module tpose_nxn_dbuf_lane #(
    parameter int N    = 8,
    parameter int W    = 16,
    parameter int LANE = 0
) (
    input  logic [N-1:0][N-1:0][W-1:0] bank,
    input  logic [$clog2(N)-1:0]       u,
    input  logic                       byp,
    output logic [W-1:0]               tok
);
    // bank[t][i] holds input vector t, channel i
    assign tok = byp ? bank[u][LANE] : bank[LANE][u];
endmodule

module tpose_nxn_dbuf #(
    parameter int N = 8,
    parameter int W = 16
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N*W-1:0] a_d,
    input  logic [N-1:0]   a_e,
    input  logic [N-1:0]   a_v,
    output logic [N-1:0]   a_b,
    output logic [N*W-1:0] b_d,
    output logic [N-1:0]   b_e,
    output logic [N-1:0]   b_v,
    input  logic [N-1:0]   b_b,
    input  logic           bypass,
    output logic           err
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {RUN, DRAIN, EOSOUT} state_t;

    state_t                          state, state_nxt;
    logic [1:0][N-1:0][N-1:0][W-1:0] mem;
    logic [1:0]                      full;
    logic [1:0]                      mode;
    logic                            wr_sel, rd_sel;
    logic [CW-1:0]                   wr_cnt, rd_cnt;
    logic                            byp_lat;
    logic [N-1:0][W-1:0]             lane_tok;

    logic wr_ready, acc, eos_v, mixed_v, data_v, last_wr;
    logic vld, rd_adv, last_rd;

    assign wr_ready = ~full[wr_sel] & (state == RUN);
    assign acc      = wr_ready & (&a_v);
    assign a_b      = {N{~acc}};
    assign eos_v    = acc & (&a_e);
    assign mixed_v  = acc & (|a_e) & ~(&a_e);
    assign data_v   = acc & ~(|a_e);
    assign last_wr  = (wr_cnt == CW'(N - 1));

    // EOSOUT owns the output port; data banks only drive it in RUN/DRAIN
    assign vld     = (state != EOSOUT) & full[rd_sel];
    assign rd_adv  = vld & ~(|b_b);
    assign last_rd = (rd_cnt == CW'(N - 1));

    genvar r;
    generate
        for (r = 0; r < N; r++) begin : g_lane
            tpose_nxn_dbuf_lane #(.N(N), .W(W), .LANE(r)) u_lane (
                .bank (mem[rd_sel]),
                .u    (rd_cnt),
                .byp  (mode[rd_sel]),
                .tok  (lane_tok[r])
            );
        end
    endgenerate

    assign b_v = (state == EOSOUT) ? {N{1'b1}} : {N{vld}};
    assign b_e = {N{state == EOSOUT}};
    assign b_d = vld ? lane_tok : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (eos_v) state_nxt = DRAIN;
            DRAIN:   if (full == 2'b00) state_nxt = EOSOUT;
            EOSOUT:  if (~(|b_b)) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= RUN;
            mem     <= '0;
            full    <= '0;
            mode    <= '0;
            wr_sel  <= 1'b0;
            rd_sel  <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            byp_lat <= 1'b0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (mixed_v || (eos_v && wr_cnt != '0)) err <= 1'b1;
            // EOS abandons any partially filled bank
            if (eos_v) wr_cnt <= '0;
            if (data_v) begin
                mem[wr_sel][wr_cnt] <= a_d;
                if (wr_cnt == '0) byp_lat <= bypass;
                if (last_wr) begin
                    full[wr_sel] <= 1'b1;
                    mode[wr_sel] <= byp_lat;
                    wr_sel       <= ~wr_sel;
                    wr_cnt       <= '0;
                end else begin
                    wr_cnt <= wr_cnt + CW'(1);
                end
            end
            // a write only targets a non-full bank, so it never collides with the read bank
            if (rd_adv) begin
                if (last_rd) begin
                    full[rd_sel] <= 1'b0;
                    rd_sel       <= ~rd_sel;
                    rd_cnt       <= '0;
                end else begin
                    rd_cnt <= rd_cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_tpose_nxn_dbuf.sv
// Directed bench for tpose_nxn_dbuf: driver pushes expected vectors into a
// scoreboard queue, an independent monitor pops them on every output transfer.

module tb_tpose_nxn_dbuf;
    localparam int N = 8;
    localparam int W = 16;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N*W-1:0] a_d = '0;
    logic [N-1:0]   a_e = '0;
    logic [N-1:0]   a_v = '0;
    logic [N-1:0]   a_b;
    logic [N*W-1:0] b_d;
    logic [N-1:0]   b_e;
    logic [N-1:0]   b_v;
    logic [N-1:0]   b_b = '0;
    logic           bypass = 1'b0;
    logic           err;

    tpose_nxn_dbuf #(.N(N), .W(W)) dut (
        .clock(clock), .reset(reset), .a_d(a_d), .a_e(a_e), .a_v(a_v), .a_b(a_b),
        .b_d(b_d), .b_e(b_e), .b_v(b_v), .b_b(b_b), .bypass(bypass), .err(err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [N*W-1:0] d;
        logic           e;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_xfer = -10;
    int   runs = 0;
    int   n_out = 0;

    localparam logic [N-1:0] ALL1 = {N{1'b1}};

    task automatic chk(input string nm, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] val(input int base, input int t, input int i);
        return W'(base + 16 * t + i);
    endfunction

    function automatic logic [N*W-1:0] vec(input int base, input int t);
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) d[i*W +: W] = val(base, t, i);
        return d;
    endfunction

    // Transposed: out u chan r = X[r][u]; bypass: out u chan r = X[u][r]
    task automatic push_block(input int base, input logic byp);
        exp_t e;
        for (int u = 0; u < N; u++) begin
            for (int r = 0; r < N; r++)
                e.d[r*W +: W] = byp ? val(base, u, r) : val(base, r, u);
            e.e = 1'b0;
            sb.push_back(e);
        end
    endtask

    task automatic send_vec(input logic [N*W-1:0] d, input logic [N-1:0] e,
                            input logic byp, output int waits);
        logic took;
        a_d = d; a_e = e; a_v = ALL1; bypass = byp;
        waits = 0; took = 1'b0;
        while (!took && waits < 200) begin
            @(negedge clock);
            took = (a_b == '0);
            if (!took) waits++;
            @(posedge clock); #1;
        end
        if (!took) chk("send_timeout", {{(N*W-1){1'b0}}, took}, 1);
    endtask

    task automatic send_block(input int base, input logic byp, output int w0, output int wr);
        int w;
        wr = 0;
        for (int t = 0; t < N; t++) begin
            send_vec(vec(base, t), '0, byp, w);
            if (t == 0) w0 = w; else wr += w;
        end
        push_block(base, byp);
    endtask

    task automatic send_eos();
        int   w;
        exp_t e;
        send_vec('0, ALL1, 1'b0, w);
        e.d = '0; e.e = 1'b1;
        sb.push_back(e);
    endtask

    task automatic idle();
        a_v = '0; a_e = '0; a_d = '0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((sb.size() != 0 || b_v != '0) && k < 300) begin
            @(posedge clock); #1;
            k++;
        end
        chk("drain_sb_empty", sb.size(), 0);
        chk("drain_bv_low", b_v, 0);
    endtask

    // Monitor: every output transfer pops one expected vector
    always @(negedge clock) begin
        cyc++;
        if (!reset) begin
            chk("rst_bv", b_v, 0);
            chk("rst_bd", b_d, 0);
        end else begin
            if (b_v != '0 && b_v != ALL1) chk("bv_all_or_none", b_v, ALL1);
            if (b_v == ALL1 && b_b == '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", b_d, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("out_bd", b_d, mon_e.d);
                    chk("out_be", b_e, {N{mon_e.e}});
                end
                if (last_xfer != cyc - 1) runs++;
                last_xfer = cyc;
                n_out++;
            end
        end
    end

    initial begin
        int w0, wr, s, r0, n0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_bv_init", b_v, 0);
        chk("rst_be_init", b_e, 0);
        chk("rst_bd_init", b_d, 0);
        chk("rst_err_init", err, 0);
        chk("rst_ab_init", a_b, ALL1);
        reset = 1'b1;
        @(posedge clock); #1;

        // 1: basic transpose, latency and hand-computed tokens
        send_block(0, 1'b0, w0, wr);
        idle();
        chk("t1_latency_bv", b_v, ALL1);
        chk("t1_u0_r5", b_d[5*W +: W], 16'h0050);
        repeat (2) begin @(posedge clock); #1; end
        chk("t1_u2_r5", b_d[5*W +: W], 16'h0052);
        wait_drain();

        // 2: three blocks back to back, no input stalls, no output gaps
        r0 = runs; n0 = n_out;
        send_block(16'h1000, 1'b0, w0, wr); s = wr;
        send_block(16'h2000, 1'b0, w0, wr); s += w0 + wr;
        send_block(16'h3000, 1'b0, w0, wr); s += w0 + wr;
        idle();
        chk("t2_input_stalls", s, 0);
        wait_drain();
        chk("t2_out_count", n_out - n0, 24);
        chk("t2_out_runs", runs - r0, 1);

        // 3: consumer stalled, both banks fill, then release
        b_b = ALL1;
        send_block(16'h0100, 1'b0, w0, wr);
        send_block(16'h0200, 1'b0, w0, wr);
        a_d = vec(16'h0300, 0); a_v = ALL1; a_e = '0;
        repeat (3) @(negedge clock);
        chk("t3_ab_full", a_b, ALL1);
        chk("t3_bv_held", b_v, ALL1);
        @(posedge clock); #1;
        b_b = '0;
        send_block(16'h0300, 1'b0, w0, wr);
        idle();
        wait_drain();

        // 4: one channel late, vector held until all valid
        a_d = vec(16'h0400, 0); a_v = 8'hF7; a_e = '0;
        repeat (2) begin
            @(negedge clock);
            chk("t4_ab_partial_valid", a_b, ALL1);
            @(posedge clock); #1;
        end
        send_block(16'h0400, 1'b0, w0, wr);
        idle();
        wait_drain();

        // 5: clean EOS, mixed EOS flags, EOS after partial block
        send_block(16'h0500, 1'b0, w0, wr);
        send_eos();
        idle();
        wait_drain();
        chk("t5_err_clean", err, 0);
        send_vec(vec(16'h0600, 0), 8'h01, 1'b0, w0);
        idle();
        @(posedge clock); #1;
        chk("t5_err_mixed", err, 1);
        for (int t = 0; t < 3; t++) send_vec(vec(16'h0700, t), '0, 1'b0, w0);
        send_eos();
        idle();
        wait_drain();
        chk("t5_err_partial", err, 1);

        // 6: bypass block, then reset mid-block
        send_block(16'h0800, 1'b0, w0, wr);
        send_block(16'h0900, 1'b1, w0, wr);
        idle();
        wait_drain();
        b_b = ALL1;
        send_block(16'h0A00, 1'b0, w0, wr);
        for (int t = 0; t < 3; t++) send_vec(vec(16'h0B00, t), '0, 1'b0, w0);
        idle();
        chk("t6_bv_before_rst", b_v, ALL1);
        reset = 1'b0;
        #1;
        chk("t6_rst_bv", b_v, 0);
        chk("t6_rst_bd", b_d, 0);
        chk("t6_rst_err", err, 0);
        sb.delete();
        b_b = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        send_block(16'h0C00, 1'b1, w0, wr);
        idle();
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
